// File: rtl/ram_arbiter_2p.sv
// Two-port round-robin arbiter in front of a single-port 4K x 32 SRAM macro.
// Port 0 is instruction fetch, port 1 is data/DMA; read data returns one cycle after grant.
module ram_arbiter_2p #(
  parameter int AW         = 13,
  parameter int DEPTH_LOG2 = 12,
  parameter int FIXED_PRIO = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [AW-1:0] A0,
  input  logic [3:0]    WE0,
  input  logic [31:0]   WDATA0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic          RERR0,
  output logic [31:0]   RDATA0,
  input  logic          REQ1,
  input  logic [AW-1:0] A1,
  input  logic [3:0]    WE1,
  input  logic [31:0]   WDATA1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic          RERR1,
  output logic [31:0]   RDATA1,
  output logic          RAM_EN,
  output logic [3:0]    RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [31:0]   RAM_Di,
  input  logic [31:0]   RAM_Do
);

  logic          last_gnt;
  logic          pick1;
  logic          any_gnt;
  logic          in_range;
  logic          is_rd;
  logic [AW-1:0] sel_a;
  logic [3:0]    sel_we;
  logic [31:0]   sel_wd;

  logic          rd_pend;
  logic          rd_port;
  logic          rd_ok;
  logic [31:0]   rd_data;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;

  // last_gnt = 1 means port 1 was granted most recently
  always_comb begin
    pick1 = 1'b0;
    if (REQ0 && REQ1)
      pick1 = (FIXED_PRIO == 0) && !last_gnt;
    else
      pick1 = REQ1;
  end

  assign GNT0    = !RST && REQ0 && !pick1;
  assign GNT1    = !RST && REQ1 && pick1;
  assign any_gnt = GNT0 || GNT1;

  assign sel_a    = pick1 ? A1 : A0;
  assign sel_we   = pick1 ? WE1 : WE0;
  assign sel_wd   = pick1 ? WDATA1 : WDATA0;
  assign in_range = (sel_a >> DEPTH_LOG2) == '0;
  assign is_rd    = any_gnt && (sel_we == 4'b0000);

  assign RAM_EN = any_gnt && in_range;
  assign RAM_WE = any_gnt ? sel_we : 4'b0000;
  assign RAM_A  = sel_a;
  assign RAM_Di = sel_wd;

  assign rd_data = rd_ok ? RAM_Do : 32'h0;

  assign RVALID0 = rd_pend && !rd_port && !RST;
  assign RVALID1 = rd_pend && rd_port && !RST;
  assign RERR0   = RVALID0 && !rd_ok;
  assign RERR1   = RVALID1 && !rd_ok;
  assign RDATA0  = RVALID0 ? rd_data : rdata0_q;
  assign RDATA1  = RVALID1 ? rd_data : rdata1_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt <= 1'b1;
      rd_pend  <= 1'b0;
      rd_port  <= 1'b0;
      rd_ok    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      if (any_gnt)
        last_gnt <= GNT1;
      rd_pend <= is_rd;
      rd_port <= GNT1;
      rd_ok   <= in_range;
      if (RVALID0)
        rdata0_q <= rd_data;
      if (RVALID1)
        rdata1_q <= rd_data;
    end
  end

endmodule
